// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: ping-pong capture of streamed samples into frames presented to the FFT.
module audio_frame_buffer #(
  parameter int SAMPLE_W  = 24,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  input  logic                          frame_completed,
  output logic [FRAME_LEN*SAMPLE_W-1:0] frame_data,
  output logic                          Ready,
  output logic [$clog2(FRAME_LEN):0]    fill_level,
  output logic                          overrun,
  output logic [CNT_W-1:0]              overrun_count
);
  localparam int IW = $clog2(FRAME_LEN);
  logic [SAMPLE_W-1:0] mem [2][FRAME_LEN];
  logic [1:0]          full;
  logic                wr_sel, rd_sel;
  logic [IW-1:0]       wr_idx;
  assign Ready      = full[rd_sel];
  assign fill_level = {1'b0, wr_idx};
  for (genvar k = 0; k < FRAME_LEN; k++) begin : g_slot
    assign frame_data[k*SAMPLE_W +: SAMPLE_W] = mem[rd_sel][k];
  end
  // Write and release target different banks whenever both act, so both updates can land together.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      mem           <= '{default: '0};
      full          <= '0;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      wr_idx        <= '0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      overrun <= sample_valid && full[wr_sel];
      if (sample_valid && !full[wr_sel]) begin
        mem[wr_sel][wr_idx] <= sample_in;
        wr_idx              <= wr_idx + 1'b1;
        if (&wr_idx) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end
      end else if (sample_valid && !(&overrun_count))
        overrun_count <= overrun_count + 1'b1;
      if (frame_completed && full[rd_sel]) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
endmodule
